// File: rtl/ula_pkg.sv
// ula_pkg: shared definitions for the two-requester ALU arbiter.
//   - ALU-control codes (effective operation after aluOp/funct decode)
//   - MIPS funct and aluOp constants
//   - arbiter FSM state type
//   - decode_op(): aluOp/funct -> effective operation, used for overflow detection
package ula_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLL = 3'd4,
    ALU_SRL = 3'd5,
    ALU_SRA = 3'd6,
    ALU_SLT = 3'd7
  } alu_ctrl_e;

  localparam logic [5:0] FUNCT_SLL = 6'd0;
  localparam logic [5:0] FUNCT_SRL = 6'd2;
  localparam logic [5:0] FUNCT_SRA = 6'd3;
  localparam logic [5:0] FUNCT_ADD = 6'd32;
  localparam logic [5:0] FUNCT_SUB = 6'd34;
  localparam logic [5:0] FUNCT_AND = 6'd36;
  localparam logic [5:0] FUNCT_OR  = 6'd37;
  localparam logic [5:0] FUNCT_SLT = 6'd42;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_AND   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;
  localparam logic [1:0] ALUOP_ADD3  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Effective operation the external ALU performs for a given control pair.
  // Unknown funct codes fall back to ADD, matching the ALU's own default.
  function automatic alu_ctrl_e decode_op(input logic [1:0] aluop, input logic [5:0] funct);
    alu_ctrl_e op;
    op = ALU_ADD;
    case (aluop)
      ALUOP_ADD:  op = ALU_ADD;
      ALUOP_AND:  op = ALU_AND;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_SLL: op = ALU_SLL;
          FUNCT_SRL: op = ALU_SRL;
          FUNCT_SRA: op = ALU_SRA;
          FUNCT_ADD: op = ALU_ADD;
          FUNCT_SUB: op = ALU_SUB;
          FUNCT_AND: op = ALU_AND;
          FUNCT_OR:  op = ALU_OR;
          FUNCT_SLT: op = ALU_SLT;
          default:   op = ALU_ADD;
        endcase
      end
      ALUOP_ADD3: op = ALU_ADD;
      default:    op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ula_rr_arbiter.sv
// ula_rr_arbiter: combinational 2-way round-robin grant.
//   req      in  2  request lines
//   ptr      in  1  requester that wins when both request
//   grant    out 2  one-hot grant (zero when no request)
//   grant_id out 1  index of the granted requester (0 when no request)
module ula_rr_arbiter (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       grant_id
);

  always_comb begin
    grant    = 2'b00;
    grant_id = 1'b0;
    if (req[0] && req[1]) begin
      grant_id = ptr;
      grant    = ptr ? 2'b10 : 2'b01;
    end else if (req[0]) begin
      grant_id = 1'b0;
      grant    = 2'b01;
    end else if (req[1]) begin
      grant_id = 1'b1;
      grant    = 2'b10;
    end
  end

endmodule

// File: rtl/ula_arbiter.sv
// ula_arbiter: shares one combinational ALU between two requesters.
//   req_valid/req_ready         per-requester request handshake (ready only in IDLE)
//   req_in1/in2/shamt/aluop/funct packed per-requester operation fields
//   alu_*                        registered operation to the ALU, nonzero only in EXEC
//   alu_result                   combinational ALU result, captured at end of EXEC
//   resp_valid/resp_ready        per-requester response handshake (one-hot valid)
//   resp_data/resp_ovf           captured result and signed ADD/SUB overflow
// Flow: IDLE (grant+accept) -> EXEC (ALU driven) -> RESP (hold until owner takes it).
module ula_arbiter
  import ula_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*WIDTH-1:0]   req_in1,
  input  logic [2*WIDTH-1:0]   req_in2,
  input  logic [2*SHAMT_W-1:0] req_shamt,
  input  logic [3:0]           req_aluop,
  input  logic [11:0]          req_funct,
  output logic [WIDTH-1:0]     alu_in1,
  output logic [WIDTH-1:0]     alu_in2,
  output logic [SHAMT_W-1:0]   alu_shamt,
  output logic [1:0]           alu_aluop,
  output logic [5:0]           alu_funct,
  input  logic [WIDTH-1:0]     alu_result,
  output logic [1:0]           resp_valid,
  input  logic [1:0]           resp_ready,
  output logic [WIDTH-1:0]     resp_data,
  output logic                 resp_ovf
);

  state_e state_reg;
  logic   ptr_reg;
  logic   id_reg;

  logic [1:0] grant;
  logic       grant_id;
  logic       accept;

  logic [WIDTH-1:0]   in1_arr   [2];
  logic [WIDTH-1:0]   in2_arr   [2];
  logic [SHAMT_W-1:0] shamt_arr [2];
  logic [1:0]         aluop_arr [2];
  logic [5:0]         funct_arr [2];

  alu_ctrl_e op;
  logic      ovf_next;

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign in1_arr[gi]   = req_in1[gi*WIDTH +: WIDTH];
    assign in2_arr[gi]   = req_in2[gi*WIDTH +: WIDTH];
    assign shamt_arr[gi] = req_shamt[gi*SHAMT_W +: SHAMT_W];
    assign aluop_arr[gi] = req_aluop[gi*2 +: 2];
    assign funct_arr[gi] = req_funct[gi*6 +: 6];
  end

  ula_rr_arbiter u_rr (
    .req      (req_valid),
    .ptr      (ptr_reg),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign req_ready = (state_reg == IDLE && !reset) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);

  // The alu_* registers double as the captured operation, so overflow is
  // computed from them against the live ALU result during EXEC.
  always_comb begin
    op       = decode_op(alu_aluop, alu_funct);
    ovf_next = 1'b0;
    case (op)
      ALU_ADD: ovf_next = (alu_in1[WIDTH-1] == alu_in2[WIDTH-1]) &&
                          (alu_result[WIDTH-1] != alu_in1[WIDTH-1]);
      ALU_SUB: ovf_next = (alu_in1[WIDTH-1] != alu_in2[WIDTH-1]) &&
                          (alu_result[WIDTH-1] != alu_in1[WIDTH-1]);
      default: ovf_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      ptr_reg    <= 1'b0;
      id_reg     <= 1'b0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_shamt  <= '0;
      alu_aluop  <= '0;
      alu_funct  <= '0;
      resp_valid <= 2'b00;
      resp_data  <= '0;
      resp_ovf   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            id_reg    <= grant_id;
            alu_in1   <= in1_arr[grant_id];
            alu_in2   <= in2_arr[grant_id];
            alu_shamt <= shamt_arr[grant_id];
            alu_aluop <= aluop_arr[grant_id];
            alu_funct <= funct_arr[grant_id];
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          resp_data  <= alu_result;
          resp_ovf   <= ovf_next;
          resp_valid <= id_reg ? 2'b10 : 2'b01;
          alu_in1    <= '0;
          alu_in2    <= '0;
          alu_shamt  <= '0;
          alu_aluop  <= '0;
          alu_funct  <= '0;
          state_reg  <= RESP;
        end
        RESP: begin
          // Only the owner's ready matters; the other requester is ignored.
          if (resp_ready[id_reg]) begin
            resp_valid <= 2'b00;
            resp_data  <= '0;
            resp_ovf   <= 1'b0;
            ptr_reg    <= ~id_reg;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed testbench for ula_arbiter with a behavioural ALU model on alu_*.
module tb_ula_arbiter;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic                 clk;
  logic                 reset;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [2*WIDTH-1:0]   req_in1;
  logic [2*WIDTH-1:0]   req_in2;
  logic [2*SHAMT_W-1:0] req_shamt;
  logic [3:0]           req_aluop;
  logic [11:0]          req_funct;
  logic [WIDTH-1:0]     alu_in1;
  logic [WIDTH-1:0]     alu_in2;
  logic [SHAMT_W-1:0]   alu_shamt;
  logic [1:0]           alu_aluop;
  logic [5:0]           alu_funct;
  logic [WIDTH-1:0]     alu_result;
  logic [1:0]           resp_valid;
  logic [1:0]           resp_ready;
  logic [WIDTH-1:0]     resp_data;
  logic                 resp_ovf;

  int checks;
  int failures;

  ula_arbiter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_in1    (req_in1),
    .req_in2    (req_in2),
    .req_shamt  (req_shamt),
    .req_aluop  (req_aluop),
    .req_funct  (req_funct),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_shamt  (alu_shamt),
    .alu_aluop  (alu_aluop),
    .alu_funct  (alu_funct),
    .alu_result (alu_result),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_ovf   (resp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational MIPS-style ALU (shifts operate on input1).
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] sh, input logic [1:0] aop,
                                            input logic [5:0] fn);
    logic [31:0] r;
    r = a + b;
    case (aop)
      2'd1: r = a & b;
      2'd2: begin
        case (fn)
          6'd0:  r = a << sh;
          6'd2:  r = a >> sh;
          6'd3:  r = $unsigned($signed(a) >>> sh);
          6'd34: r = a - b;
          6'd36: r = a & b;
          6'd37: r = a | b;
          6'd42: r = {31'd0, $signed(a) < $signed(b)};
          default: r = a + b;
        endcase
      end
      default: r = a + b;
    endcase
    return r;
  endfunction

  assign alu_result = alu_model(alu_in1, alu_in2, alu_shamt, alu_aluop, alu_funct);

  // Stimulus-only helper: place one requester's operation fields.
  task automatic set_fields(input int r, input logic [1:0] aop, input logic [5:0] fn,
                            input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    req_in1[r*WIDTH +: WIDTH]       = a;
    req_in2[r*WIDTH +: WIDTH]       = b;
    req_shamt[r*SHAMT_W +: SHAMT_W] = sh;
    req_aluop[r*2 +: 2]             = aop;
    req_funct[r*6 +: 6]             = fn;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
    req_in1 = '0; req_in2 = '0; req_shamt = '0; req_aluop = '0; req_funct = '0;
    repeat (2) @(posedge clk);
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b00 || resp_valid !== 2'b00 || resp_data !== 32'd0 || resp_ovf !== 1'b0 ||
        alu_in1 !== 32'd0 || alu_in2 !== 32'd0 || alu_shamt !== 5'd0 || alu_aluop !== 2'd0 ||
        alu_funct !== 6'd0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b rv=%b rd=%h ovf=%b a1=%h expected all zero",
               req_ready, resp_valid, resp_data, resp_ovf, alu_in1);
    end
    @(negedge clk);
    req_valid = 2'b00;
    reset = 1'b0;
    $display("reset: outputs checked while reset held");
  endtask

  // One complete operation from a single requester with resp_ready=11.
  task automatic test_single_op(input string name, input int r, input logic [1:0] aop,
                                input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, input logic [31:0] exp_data,
                                input logic exp_ovf);
    logic [1:0] exp_oh;
    exp_oh = (r == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    set_fields(r, aop, fn, a, b, sh);
    resp_ready = 2'b11;
    req_valid = exp_oh;
    #1;
    checks++;
    if (req_ready !== exp_oh) begin
      failures++;
      $display("FAIL %s_req_ready got=%b expected=%b", name, req_ready, exp_oh);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    checks++;
    if (alu_in1 !== a || alu_in2 !== b || alu_shamt !== sh || alu_aluop !== aop || alu_funct !== fn) begin
      failures++;
      $display("FAIL %s_exec_alu got=%h/%h/%0d/%0d/%0d expected=%h/%h/%0d/%0d/%0d", name,
               alu_in1, alu_in2, alu_shamt, alu_aluop, alu_funct, a, b, sh, aop, fn);
    end
    checks++;
    if (req_ready !== 2'b00 || resp_valid !== 2'b00) begin
      failures++;
      $display("FAIL %s_exec_quiet got rdy=%b rv=%b expected 00/00", name, req_ready, resp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== exp_oh || resp_data !== exp_data || resp_ovf !== exp_ovf) begin
      failures++;
      $display("FAIL %s_resp got rv=%b data=%h ovf=%b expected rv=%b data=%h ovf=%b", name,
               resp_valid, resp_data, resp_ovf, exp_oh, exp_data, exp_ovf);
    end
    checks++;
    if (alu_in1 !== 32'd0 || alu_aluop !== 2'd0 || alu_funct !== 6'd0 || alu_shamt !== 5'd0) begin
      failures++;
      $display("FAIL %s_alu_idle got a1=%h op=%0d fn=%0d sh=%0d expected zero", name,
               alu_in1, alu_aluop, alu_funct, alu_shamt);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 2'b00) begin
      failures++;
      $display("FAIL %s_resp_clear got=%b expected=00", name, resp_valid);
    end
    $display("op %s: req%0d data=%h ovf=%b", name, r, resp_data, resp_ovf);
  endtask

  // Both requesters continuously valid: grants must alternate 0,1,0,1.
  task automatic test_fairness();
    logic [1:0]  exp_oh;
    logic [31:0] exp_a1;
    logic [31:0] exp_d;
    @(negedge clk);
    set_fields(0, 2'd0, 6'd0, 32'd10, 32'd1, 5'd0);
    set_fields(1, 2'd0, 6'd0, 32'd20, 32'd2, 5'd0);
    resp_ready = 2'b11;
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_a1 = (k % 2 == 0) ? 32'd10 : 32'd20;
      exp_d  = (k % 2 == 0) ? 32'd11 : 32'd22;
      checks++;
      if (req_ready !== exp_oh) begin
        failures++;
        $display("FAIL fair%0d_grant got=%b expected=%b", k, req_ready, exp_oh);
      end
      @(posedge clk); #1;
      checks++;
      if (alu_in1 !== exp_a1) begin
        failures++;
        $display("FAIL fair%0d_alu_in1 got=%h expected=%h", k, alu_in1, exp_a1);
      end
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== exp_oh || resp_data !== exp_d) begin
        failures++;
        $display("FAIL fair%0d_resp got rv=%b data=%h expected rv=%b data=%h", k,
                 resp_valid, resp_data, exp_oh, exp_d);
      end
      checks++;
      if (req_ready !== 2'b00) begin
        failures++;
        $display("FAIL fair%0d_no_b2b got=%b expected=00", k, req_ready);
      end
      $display("fair op %0d: grant=%b data=%h", k, exp_oh, resp_data);
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
  endtask

  // Requester 0 stalls its response; requester 1's ready and request are ignored.
  task automatic test_backpressure();
    @(negedge clk);
    set_fields(0, 2'd0, 6'd0, 32'd3, 32'd4, 5'd0);
    set_fields(1, 2'd1, 6'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    resp_ready = 2'b10;
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b10;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp_valid !== 2'b01 || resp_data !== 32'd7 || resp_ovf !== 1'b0) begin
        failures++;
        $display("FAIL stall%0d_resp got rv=%b data=%h ovf=%b expected rv=01 data=00000007 ovf=0",
                 i, resp_valid, resp_data, resp_ovf);
      end
      checks++;
      if (req_ready !== 2'b00) begin
        failures++;
        $display("FAIL stall%0d_req_ready got=%b expected=00", i, req_ready);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    resp_ready = 2'b01;
    req_valid = 2'b00;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 2'b00) begin
      failures++;
      $display("FAIL stall_release got=%b expected=00", resp_valid);
    end
    $display("backpressure: 5 stalled cycles then release");
  endtask

  // Async reset during EXEC abandons the operation and restores pointer 0.
  task automatic test_reset_mid();
    @(negedge clk);
    set_fields(1, 2'd2, 6'd34, 32'd50, 32'd8, 5'd0);
    resp_ready = 2'b11;
    req_valid = 2'b10;
    @(posedge clk); #1;
    req_valid = 2'b00;
    checks++;
    if (alu_in1 !== 32'd50 || alu_funct !== 6'd34) begin
      failures++;
      $display("FAIL rstmid_exec got a1=%h fn=%0d expected a1=00000032 fn=34", alu_in1, alu_funct);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (alu_in1 !== 32'd0 || alu_in2 !== 32'd0 || alu_funct !== 6'd0 || alu_aluop !== 2'd0 ||
        resp_valid !== 2'b00 || req_ready !== 2'b00 || resp_data !== 32'd0) begin
      failures++;
      $display("FAIL rstmid_async got a1=%h a2=%h fn=%0d rv=%b rdy=%b expected zero",
               alu_in1, alu_in2, alu_funct, resp_valid, req_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL rstmid_ptr got=%b expected=01", req_ready);
    end
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 2'b00 || alu_in1 !== 32'd0) begin
        failures++;
        $display("FAIL rstmid_stale%0d got rv=%b a1=%h expected 00/0", i, resp_valid, alu_in1);
      end
    end
    $display("reset mid-EXEC: operation abandoned");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_op("add_basic", 0, 2'd2, 6'd32, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0);
    test_single_op("sub_ovf",   1, 2'd2, 6'd34, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF, 1'b1);
    test_single_op("add_ovf",   0, 2'd0, 6'd0,  32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b1);
    test_single_op("and_op1",   1, 2'd1, 6'd0,  32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0, 32'h0F0F_0000, 1'b0);
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_single_op("sll31",     0, 2'd2, 6'd0,  32'd1, 32'd0, 5'd31, 32'h8000_0000, 1'b0);
    test_single_op("add3_ovf",  1, 2'd3, 6'd0,  32'h8000_0000, 32'h8000_0000, 5'd0, 32'd0, 1'b1);
    test_single_op("slt_noovf", 0, 2'd2, 6'd42, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout reached at %0t expected completion earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
